// File: rtl/pipelined_adder_nb.sv
// pipelined_adder_nb
//   Pipelined WIDTH-bit adder/subtractor. The operands are added in SLICE-bit
//   carry-ripple stages with one register stage per slice. Upper operand
//   slices wait in skew registers until their stage, and the finished lower
//   sum slices travel in deskew registers so that the whole result comes out
//   at once, STAGES = WIDTH/SLICE cycles after the operands are presented.
//   WIDTH must be a multiple of SLICE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every pipeline register
//   in_valid   operands and mode are valid this cycle
//   in_ready   block accepts operands this cycle (= global advance)
//   a, b       WIDTH-bit operands
//   c_in       carry-in, used only when sub=0
//   sub        0: a+b+c_in, 1: a-b (a + ~b + 1)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   c_out      carry out of the MSB (for sub, 1 means no borrow)
//   overflow   signed overflow flag
module pipelined_adder_nb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / SLICE;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             ov_d, ov_q;

  always_comb begin
    b_eff = sub ? ~b : b;
    cin0  = sub | c_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SLICE;

    logic [SLICE-1:0]    a_sl, b_sl;
    logic                c_sl, v_sl;
    logic [SLICE:0]      add;
    logic                v_d, v_q;
    logic                c_d, c_q;
    logic [LO+SLICE-1:0] s_d, s_q;

    // Operand slice, carry and valid come straight from the ports for the
    // first stage and from the previous stage's registers afterwards.
    if (k == 0) begin : g_first
      always_comb begin
        a_sl = a[SLICE-1:0];
        b_sl = b_eff[SLICE-1:0];
        c_sl = cin0;
        v_sl = in_valid;
        s_d  = add[SLICE-1:0];
      end
    end else begin : g_next
      always_comb begin
        a_sl = g_stage[k-1].g_skew.a_sk_q[SLICE-1:0];
        b_sl = g_stage[k-1].g_skew.b_sk_q[SLICE-1:0];
        c_sl = g_stage[k-1].c_q;
        v_sl = g_stage[k-1].v_q;
        s_d  = {add[SLICE-1:0], g_stage[k-1].s_q};
      end
    end

    always_comb begin
      add = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_sl};
      c_d = add[SLICE];
      v_d = v_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    // Skew registers hold the operand slices not yet consumed; the lowest
    // slice of what is held feeds the next stage.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned SW = WIDTH - LO - SLICE;

      logic [SW-1:0] a_sk_d, a_sk_q;
      logic [SW-1:0] b_sk_d, b_sk_q;

      if (k == 0) begin : g_sk_first
        always_comb begin
          a_sk_d = a[WIDTH-1:SLICE];
          b_sk_d = b_eff[WIDTH-1:SLICE];
        end
      end else begin : g_sk_next
        always_comb begin
          a_sk_d = g_stage[k-1].g_skew.a_sk_q[SW+SLICE-1:SLICE];
          b_sk_d = g_stage[k-1].g_skew.b_sk_q[SW+SLICE-1:SLICE];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (adv) begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end
    end
  end

  // The final stage still sees the operand MSBs in its own slice, so the
  // overflow flag is formed there and registered alongside the last slice.
  always_comb begin
    ov_d = (g_stage[STAGES-1].a_sl[SLICE-1] == g_stage[STAGES-1].b_sl[SLICE-1]) &&
           (g_stage[STAGES-1].add[SLICE-1] != g_stage[STAGES-1].a_sl[SLICE-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else if (adv) begin
      ov_q <= ov_d;
    end
  end

  always_comb begin
    adv = !out_valid || out_ready;
  end

  assign in_ready  = adv;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_adder_nb.sv
// Directed testbench for pipelined_adder_nb (WIDTH=32, SLICE=8, 4 stages).
module tb_pipelined_adder_nb;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_adder_nb #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges from presentation until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic single(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts,
                        input logic [W-1:0] e_sum, input logic e_c, input logic e_ov);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; c_in = tc; sub = ts;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(e_sum));
    check({tag, "_cout"}, 64'(c_out), 64'(e_c));
    check({tag, "_ovf"}, 64'(overflow), 64'(e_ov));
  endtask

  initial begin
    int lat;
    int sent, rcvd, stalls, extra;
    logic prev_stall;
    logic [W-1:0] held_sum;
    logic held_c, held_ov;

    rst_n = 1'b0; in_valid = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset with garbage inputs offered.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
      #1;
      check("rst_idle", {in_ready, out_valid, c_out, overflow, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {in_ready, out_valid, sum}, {1'b1, 1'b0, 32'h0});
    end

    single("carry_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single("slice_carry", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    single("sub_neg",     32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sub_ovf",     32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-to-back pair.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h0000_00FF; b = 32'h1; c_in = 1'b0; sub = 1'b0;
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("b2b_lat", 64'(lat), 64'd3);
    check("b2b0_sum", 64'(sum), 64'h100);
    check("b2b0_cout", 64'(c_out), 64'd0);
    @(negedge clk);
    check("b2b1_valid", 64'(out_valid), 64'd1);
    check("b2b1_sum", 64'(sum), 64'h8000_0000);
    check("b2b1_ovf", 64'(overflow), 64'd1);
    @(negedge clk);
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Backpressure stream: a=i, b=i for i=0..7, out_ready low for 3 cycles.
    sent = 0; rcvd = 0; stalls = 0; prev_stall = 1'b0;
    held_sum = '0; held_c = 1'b0; held_ov = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 8);
      if (sent < 8) begin
        in_valid = 1'b1; a = 32'(sent); b = 32'(sent); c_in = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold", {out_valid, c_out, overflow, sum}, {1'b1, held_c, held_ov, held_sum});
      end
      if (out_valid && !out_ready) begin
        stalls++;
        check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      prev_stall = out_valid && !out_ready;
      held_sum = sum; held_c = c_out; held_ov = overflow;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("bp_seq", 64'(sum), 64'(2 * rcvd));
        rcvd++;
      end
    end
    check("bp_count", 64'(rcvd), 64'd8);
    check("bp_stalled", 64'(stalls), 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("bp_no_dup", 64'(extra), 64'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(32'h100 * (i + 1)); b = 32'h1; c_in = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midrst_stale", 64'(extra), 64'd0);
    single("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nb.md
Name: pipelined_adder_nb

Overview:
- Parametrised, pipelined successor to the 32-bit behavioural full adder.
- Adds or subtracts two WIDTH-bit operands in SLICE-bit carry-ripple stages, one register stage per slice.
- Valid/ready handshake on both sides with full backpressure.
- Serves as the datapath adder for wide accumulators and ALUs where a single-cycle WIDTH-bit carry chain misses timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits added per pipeline stage; STAGES = WIDTH/SLICE; latency = STAGES cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1, c_in ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  signed overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline register cleared; out_valid=0, sum=0, c_out=0, overflow=0. in_ready=1 during and after reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. All stages load only when adv=1; otherwise every stage holds.
- Transfers: an input transfer is in_valid && in_ready; an output transfer is out_valid && out_ready.
- Capture: B is inverted when sub=1. The stage-0 carry is sub ? 1 : c_in.
- Stage k (0..STAGES-1): adds slice k of A and B' plus the carry registered by stage k-1. It registers the slice sum and carry-out.
- Skew/deskew: upper slices of A and B' ride skew registers until their stage. Completed lower slices ride deskew registers so all slices of one operation emerge together.
- Valid pipeline: a STAGES-deep valid bit advances with adv. Bubbles (in_valid=0) propagate as valid=0 and occupy a slot.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+STAGES-1+1, i.e. STAGES cycles later when unstalled.
- Throughput: one operation per cycle with no stall.
- Output hold: while out_valid=1 and out_ready=0, sum, c_out and overflow are held stable and no input is accepted.
- Ordering: results emerge in input order; none are dropped or duplicated.
- c_out is the carry out of the final slice.
- overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), with both MSBs taken from the operand bits carried to the final stage.
- Wrap-around: the sum is truncated to WIDTH bits and no saturation is applied.
- Reset mid-operation: all in-flight operations are discarded, and no stale out_valid appears after reset release.
- STAGES=1 (SLICE=WIDTH) is legal and gives a single registered adder with latency 1.

Test Plan:
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> out_valid=0, sum=0, c_out=0, overflow=0, in_ready=1 throughout; release rst_n -> still idle until the first accepted input.
- Full carry chain: WIDTH=32, SLICE=8; a=0xFFFFFFFF, b=0, c_in=1, sub=0, out_ready=1 -> exactly 4 cycles later sum=0x00000000, c_out=1, overflow=0.
- Slice-boundary carry: a=0x000000FF, b=0x00000001, c_in=0 -> sum=0x00000100, c_out=0. Back-to-back next cycle: a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1.
- Subtract: a=5, b=7, sub=1, c_in=1 (ignored) -> sum=0xFFFFFFFE, c_out=0, overflow=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, c_out=1, overflow=1.
- Backpressure: stream 8 ops (a=i, b=i, i=0..7) every cycle and drop out_ready for 3 cycles mid-stream -> in_ready=0 while out_valid && !out_ready, outputs held stable, and results 0,2,4,...,14 arrive in order, each exactly once.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid falls immediately and none of the 3 results ever appear. A new op after release returns its correct sum with 4-cycle latency.
